hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline scheduler for the 5-stage core. It tracks the destination registers of instructions in flight in EX, MEM and WB in a registered shadow scoreboard.
- It drives the decode-stage forwarding selects (RAW_hazards, RAW_mem_wb_hazards), load-use stalls, bubble injection and branch/jump flushes.
- It sits beside the decode stage and feeds the fetch, decode and execute pipeline registers.

Parameters:
- CNT_W, 16, width of the saturating performance counters.
- LOAD_WB_FWD, 1, 1 = a load in WB is resolved by the decode write-back bypass; 0 = a load in WB also stalls.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_rs1  in  5  decode rs1; forced 0 for LUI by decode.
- dec_rs2  in  5  decode rs2.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_rd  in  5  decode rd.
- dec_rf_wb  in  1  decode writes the register file.
- dec_mem_load  in  1  decode is a load.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- mem_stall  in  1  memory not ready; freezes the whole pipe.
- RAW_hazards  out  4  {rs1_ex, rs2_ex, rs1_mem, rs2_mem}.
- RAW_mem_wb_hazards  out  2  {load_wb_rs1, load_wb_rs2}.
- stall_if  out  1  hold PC and the IF/DEC register.
- stall_dec  out  1  hold the DEC/EX input; inject a bubble into EX.
- flush_dec  out  1  invalidate the IF/DEC register.
- flush_ex  out  1  invalidate the DEC/EX register.
- stall_cycles  out  CNT_W  count of load-use stall cycles.
- flush_count  out  CNT_W  count of redirects.

Behaviour:
- Scoreboard: three registered entries, EX, MEM and WB. Each entry is {v, rd, wb, ld}.
- Hazard qualifier: an entry hazards rsN only when v & wb & rd!=0 & rd==rsN & dec_use_rsN & dec_valid.
- Forwarding outputs are combinational from the current scoreboard and the decode inputs:
  - rsN_ex = EX-entry hazard & !EX.ld.
  - rsN_mem = MEM-entry hazard & !MEM.ld.
  - load_wb_rsN = WB-entry hazard & WB.ld (only when LOAD_WB_FWD=1).
- Non-load hits in WB are not flagged; the decode write-back bypass resolves them.
- Load-use condition lu: a hazard on either source against an EX or MEM entry with ld=1, or against a WB entry with ld=1 when LOAD_WB_FWD=0.
  - When lu is set: stall_if=1, stall_dec=1.
  - Penalty: 2 cycles for a dependent instruction directly behind a load; 1 cycle with one instruction in between.
- Redirect (ex_redirect & !mem_stall): flush_dec=1, flush_ex=1, stall_if=0, stall_dec=0. Redirect has priority over lu.
- Advance on each edge when !mem_stall:
  - WB <= MEM; MEM <= EX.
  - EX <= {dec_valid, dec_rd, dec_rf_wb, dec_mem_load}, except EX.v <= 0 when lu or redirect is set.
- mem_stall=1: all entries hold. stall_if and stall_dec read 1; flush outputs read 0; counters hold.
- Priority order: rst > mem_stall > ex_redirect > lu.
- Counters:
  - stall_cycles increments each cycle with lu & !redirect & !mem_stall.
  - flush_count increments on each qualified redirect.
  - Both saturate at all-ones and never wrap.
- Reset: all v=0, rd=0, counters=0. Every output then reads 0 (dec_valid is irrelevant while all v=0).
- Reset mid-stall: takes effect at the next edge and clears any pending bubble.
- Both sources hitting different stages: each bit is evaluated independently. EX wins over MEM for the same source only through the decode encoder; both bits may be 1.

Test Plan:
- Forward from EX: `add x5` in EX, decode `sub x6,x5,x7` -> RAW_hazards=4'b1000, no stall.
- Load-use: `lw x3` in EX, decode `add x4,x3,x3` -> stall_if=stall_dec=1 for 2 cycles with the load in EX then MEM. Cycle 3: RAW_mem_wb_hazards=2'b11, stall=0. stall_cycles=2.
- Redirect during lu: `lw x3` in EX plus ex_redirect=1 -> flush_dec=flush_ex=1, stall=0. The next EX entry is invalid; flush_count=1.
- mem_stall held for 3 cycles with `add x5` in EX -> scoreboard frozen, RAW_hazards unchanged; after release it advances by one entry per cycle.
- x0 destination: `addi x0` in EX, decode reads x0 -> all hazard bits 0, no stall.
- Counter saturation: CNT_W=4, 20 lu cycles -> stall_cycles=4'hF. Then rst -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage core: shadow scoreboard of EX/MEM/WB destinations,
// decode forwarding selects, load-use stalls, redirect flushes and saturating event counters.
module hazard_control_unit #(
    parameter int CNT_W       = 16,
    parameter bit LOAD_WB_FWD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             dec_rf_wb,
    input  logic             dec_mem_load,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    output logic [3:0]       RAW_hazards,
    output logic [1:0]       RAW_mem_wb_hazards,
    output logic             stall_if,
    output logic             stall_dec,
    output logic             flush_dec,
    output logic             flush_ex,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wb;
        logic       ld;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: 5'd0, wb: 1'b0, ld: 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // An in-flight entry conflicts with a decode source it will overwrite.
    function automatic logic entry_hit(input sb_entry_t e, input logic [4:0] rs,
                                       input logic use_rs, input logic valid);
        return e.v & e.wb & (e.rd != 5'd0) & (e.rd == rs) & use_rs & valid;
    endfunction

    sb_entry_t        ex_r, mem_r, wb_r;
    logic [CNT_W-1:0] stall_cycles_r, flush_count_r;
    logic             ex_rs1_s, ex_rs2_s, mem_rs1_s, mem_rs2_s, wb_rs1_s, wb_rs2_s;
    logic             lu_s, redirect_s;

    // Hazard detection and pipeline control decode from scoreboard and decode fields.
    always_comb begin
        ex_rs1_s           = entry_hit(ex_r,  dec_rs1, dec_use_rs1, dec_valid);
        ex_rs2_s           = entry_hit(ex_r,  dec_rs2, dec_use_rs2, dec_valid);
        mem_rs1_s          = entry_hit(mem_r, dec_rs1, dec_use_rs1, dec_valid);
        mem_rs2_s          = entry_hit(mem_r, dec_rs2, dec_use_rs2, dec_valid);
        wb_rs1_s           = entry_hit(wb_r,  dec_rs1, dec_use_rs1, dec_valid);
        wb_rs2_s           = entry_hit(wb_r,  dec_rs2, dec_use_rs2, dec_valid);
        RAW_hazards        = {ex_rs1_s & ~ex_r.ld, ex_rs2_s & ~ex_r.ld,
                              mem_rs1_s & ~mem_r.ld, mem_rs2_s & ~mem_r.ld};
        RAW_mem_wb_hazards = 2'b00;
        if (LOAD_WB_FWD) begin
            RAW_mem_wb_hazards = {wb_rs1_s & wb_r.ld, wb_rs2_s & wb_r.ld};
        end else begin
            RAW_mem_wb_hazards = 2'b00;
        end
        lu_s = ((ex_rs1_s | ex_rs2_s) & ex_r.ld) |
               ((mem_rs1_s | mem_rs2_s) & mem_r.ld) |
               (~LOAD_WB_FWD & (wb_rs1_s | wb_rs2_s) & wb_r.ld);
        redirect_s = ex_redirect & ~mem_stall;
        stall_if   = 1'b0;
        stall_dec  = 1'b0;
        flush_dec  = 1'b0;
        flush_ex   = 1'b0;
        if (mem_stall) begin
            stall_if  = 1'b1;
            stall_dec = 1'b1;
        end else if (redirect_s) begin
            flush_dec = 1'b1;
            flush_ex  = 1'b1;
        end else if (lu_s) begin
            stall_if  = 1'b1;
            stall_dec = 1'b1;
        end else begin
            stall_if  = 1'b0;
            stall_dec = 1'b0;
        end
    end

    // Scoreboard advance and saturating counters; a memory stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r           <= SB_EMPTY;
            mem_r          <= SB_EMPTY;
            wb_r           <= SB_EMPTY;
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_count_r  <= {CNT_W{1'b0}};
        end else if (!mem_stall) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            // A stalled or flushed decode slot enters EX as a bubble.
            ex_r  <= '{v: dec_valid & ~lu_s & ~redirect_s, rd: dec_rd,
                       wb: dec_rf_wb, ld: dec_mem_load};
            if (redirect_s) begin
                flush_count_r <= (flush_count_r == CNT_MAX) ? flush_count_r
                                                             : flush_count_r + CNT_ONE;
            end else if (lu_s) begin
                stall_cycles_r <= (stall_cycles_r == CNT_MAX) ? stall_cycles_r
                                                               : stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end else begin
            ex_r           <= ex_r;
            mem_r          <= mem_r;
            wb_r           <= wb_r;
            stall_cycles_r <= stall_cycles_r;
            flush_count_r  <= flush_count_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed pipeline scenarios plus random traffic,
// checked against an age-indexed history model of issued instructions.
module tb_hazard_control_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, dec_valid, dec_use_rs1, dec_use_rs2, dec_rf_wb, dec_mem_load;
    logic             ex_redirect, mem_stall;
    logic [4:0]       dec_rs1, dec_rs2, dec_rd;
    logic [3:0]       RAW_hazards;
    logic [1:0]       RAW_mem_wb_hazards;
    logic             stall_if, stall_dec, flush_dec, flush_ex;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_control_unit #(.CNT_W(CNT_W), .LOAD_WB_FWD(1'b1)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
        .dec_rf_wb(dec_rf_wb), .dec_mem_load(dec_mem_load), .ex_redirect(ex_redirect),
        .mem_stall(mem_stall), .RAW_hazards(RAW_hazards),
        .RAW_mem_wb_hazards(RAW_mem_wb_hazards), .stall_if(stall_if), .stall_dec(stall_dec),
        .flush_dec(flush_dec), .flush_ex(flush_ex), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wb;
        bit       ld;
    } ins_t;

    // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
    ins_t hist[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_stalls = 0;
    int   m_flushes = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit dep(input int age, input bit [4:0] rs, input bit use_rs);
        ins_t e = hist[age];
        return e.v && e.wb && (e.rd != 5'd0) && (e.rd == rs) && use_rs && dec_valid;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{v: 1'b0, rd: 5'd0, wb: 1'b0, ld: 1'b0});
        m_stalls  = 0;
        m_flushes = 0;
    endfunction

    task automatic step(input bit r, input bit ms, input bit rdr, input bit dv,
                        input bit [4:0] rs1, input bit [4:0] rs2, input bit u1, input bit u2,
                        input bit [4:0] rd, input bit wb, input bit ld);
        bit [3:0] e_raw;
        bit [1:0] e_mw;
        bit       lu, redir, e_sif, e_sdec, e_fl;
        ins_t     n;
        rst = r; mem_stall = ms; ex_redirect = rdr; dec_valid = dv;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs1 = u1; dec_use_rs2 = u2;
        dec_rd = rd; dec_rf_wb = wb; dec_mem_load = ld;
        @(negedge clk);
        e_raw = {dep(0, rs1, u1) && !hist[0].ld, dep(0, rs2, u2) && !hist[0].ld,
                 dep(1, rs1, u1) && !hist[1].ld, dep(1, rs2, u2) && !hist[1].ld};
        e_mw  = {dep(2, rs1, u1) && hist[2].ld, dep(2, rs2, u2) && hist[2].ld};
        lu = 1'b0;
        for (int a = 0; a < 2; a++)
            if (hist[a].ld && (dep(a, rs1, u1) || dep(a, rs2, u2))) lu = 1'b1;
        redir  = rdr && !ms;
        e_sif  = ms || (!redir && lu);
        e_sdec = e_sif;
        e_fl   = redir;
        check_eq("RAW_hazards", RAW_hazards, e_raw);
        check_eq("RAW_mem_wb_hazards", RAW_mem_wb_hazards, e_mw);
        check_eq("stall_if", stall_if, e_sif);
        check_eq("stall_dec", stall_dec, e_sdec);
        check_eq("flush_dec", flush_dec, e_fl);
        check_eq("flush_ex", flush_ex, e_fl);
        check_eq("stall_cycles", stall_cycles, m_stalls);
        check_eq("flush_count", flush_count, m_flushes);
        if (r) begin
            model_reset();
        end else if (!ms) begin
            n = '{v: dv && !lu && !redir, rd: rd, wb: wb, ld: ld};
            hist.push_front(n);
            void'(hist.pop_back());
            if (redir) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : m_flushes;
            else if (lu) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : m_stalls;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; mem_stall = 1'b0; ex_redirect = 1'b0; dec_valid = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        dec_rd = 5'd0; dec_rf_wb = 1'b0; dec_mem_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(0);
        // Forward from EX: add x5 then sub x6,x5,x7.
        step(0, 0, 0, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        step(0, 0, 0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0);
        check_eq("fwd_ex_pattern", hist[1].rd, 5'd5);
        // x0 destination never hazards.
        step(0, 0, 0, 1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0);
        step(0, 0, 0, 1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0);
        // Load-use: lw x3, then add x4,x3,x3 held in decode until released.
        step(0, 0, 0, 1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
        repeat (3) step(0, 0, 0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        check_eq("lu_stall_cycles", stall_cycles, 2);
        // Redirect while a load-use is pending.
        step(0, 0, 0, 1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
        step(0, 0, 1, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        idle(0);
        // mem_stall for three cycles with add x5 in EX.
        step(0, 0, 0, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        repeat (3) step(0, 1, 1, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0);
        repeat (3) step(0, 0, 0, 1, 5'd5, 5'd5, 1, 1, 5'd9, 1, 0);
        // Ten load/dependent pairs drive the stall counter into saturation.
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
            repeat (3) step(0, 0, 0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        end
        check_eq("stall_saturated", stall_cycles, CMAX);
        // Reset with a pending load-use, then everything reads zero.
        step(0, 0, 0, 1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
        step(1, 0, 0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        idle(0);
        // Random traffic over a small register set to provoke frequent hazards.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
